// File: rtl/tone_gen.sv
// tone_gen -- square-wave tone generator.
//
// A requested note frequency is turned into a half-period (in clk cycles)
// by an iterative restoring divider, then played as a 50% duty square wave.
// Tone changes are committed only on a toggle edge of the running waveform,
// so switching notes never produces a short pulse or truncated half-cycle.
//
// Parameters:
//   CLK_HZ       clk frequency in Hz (16380 .. 134217726)
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   freq[11:0]   requested note in Hz, 0 = silence
//   vol[3:0]     volume, duty vol/16 inside high half-cycles
//                (present only when TONE_VOLUME_EN is defined)
//   audio_out    tone waveform
//   busy         high while a period division is running
//   half_period  half-period in clk cycles currently being played
//   tone_active  high while a nonzero tone is playing
//
// Optional feature macro: TONE_VOLUME_EN (adds vol and a 4-bit PWM gate).

module tone_gen #(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] freq,
`ifdef TONE_VOLUME_EN
  input  logic [3:0]  vol,
`endif
  output logic        audio_out,
  output logic        busy,
  output logic [25:0] half_period,
  output logic        tone_active
);

  // Half-period numerator: clk cycles per half second.
  localparam logic [25:0] DIVIDEND = 26'(CLK_HZ / 2);

  typedef enum logic [1:0] {IDLE, DIV, PEND} state_t;

  state_t      state;
  logic [11:0] freq_lat;
  logic [25:0] counter;
  logic [25:0] pend_period;
  logic        sq;

  // Divider registers: dividend shifts out MSB-first, remainder stays
  // below the divisor, quotient shifts in one bit per cycle.
  logic [25:0] dvd;
  logic [11:0] rem;
  logic [25:0] quo;
  logic [4:0]  step_cnt;

  logic [12:0] trial;
  logic        fits;
  logic [11:0] rem_next;
  logic [25:0] quo_next;
  logic        toggle_edge;

  // One restoring-division step. When the trial value fits, the difference
  // is smaller than the divisor, so a 12-bit modular subtract is exact.
  always_comb begin
    trial    = {rem, dvd[25]};
    fits     = (trial >= {1'b0, freq_lat});
    rem_next = fits ? (trial[11:0] - freq_lat) : trial[11:0];
    quo_next = {quo[24:0], fits};
  end

  assign toggle_edge = tone_active && (counter == half_period - 26'd1);

  // Controller, divider and playback share one register block. Playback
  // assignments come first so a commit in PEND can override the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      freq_lat    <= '0;
      counter     <= '0;
      pend_period <= '0;
      sq          <= 1'b0;
      dvd         <= '0;
      rem         <= '0;
      quo         <= '0;
      step_cnt    <= '0;
      busy        <= 1'b0;
      half_period <= '0;
      tone_active <= 1'b0;
    end else begin
      if (tone_active) begin
        if (toggle_edge) begin
          counter <= '0;
          sq      <= ~sq;
        end else begin
          counter <= counter + 26'd1;
        end
      end

      case (state)
        IDLE: begin
          if (freq != freq_lat) begin
            freq_lat <= freq;
            if (freq != 12'd0) begin
              dvd      <= DIVIDEND;
              rem      <= '0;
              quo      <= '0;
              step_cnt <= '0;
              busy     <= 1'b1;
              state    <= DIV;
            end else begin
              sq          <= 1'b0;
              half_period <= '0;
              tone_active <= 1'b0;
              counter     <= '0;
            end
          end
        end

        DIV: begin
          dvd      <= {dvd[24:0], 1'b0};
          rem      <= rem_next;
          quo      <= quo_next;
          step_cnt <= step_cnt + 5'd1;
          if (step_cnt == 5'd25) begin
            pend_period <= quo_next;
            busy        <= 1'b0;
            state       <= PEND;
          end
        end

        PEND: begin
          // From silence commit at once; otherwise wait for a toggle edge
          // so the old half-cycle completes in full.
          if (!tone_active || toggle_edge) begin
            half_period <= pend_period;
            counter     <= '0;
            tone_active <= 1'b1;
            if (!tone_active) begin
              sq <= 1'b0;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef TONE_VOLUME_EN
  logic [3:0] pwm_cnt;

  // Free-running PWM phase; gates the square wave to vol/16 duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign audio_out = sq & (pwm_cnt < vol);
`else
  assign audio_out = sq;
`endif

endmodule

// File: tb/tb_tone_gen.sv
// tb_tone_gen -- directed self-checking bench for tone_gen at CLK_HZ=1 MHz.
// Expected half-periods: 500000/440=1136, 500000/1000=500, 500000/659=758.
// Define TONE_VOLUME_EN to also exercise the volume gate.

module tb_tone_gen;

  localparam int CLK_HZ = 1000000;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] freq;
`ifdef TONE_VOLUME_EN
  logic [3:0]  vol;
`endif
  logic        audio_out;
  logic        busy;
  logic [25:0] half_period;
  logic        tone_active;

  int checks = 0;
  int errors = 0;

  tone_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk         (clk),
    .rst         (rst),
    .freq        (freq),
`ifdef TONE_VOLUME_EN
    .vol         (vol),
`endif
    .audio_out   (audio_out),
    .busy        (busy),
    .half_period (half_period),
    .tone_active (tone_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] f);
    freq = f;
  endtask

  // Advance n clock cycles, landing 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Number of consecutive samples (including the current one) with busy high.
  task automatic countBusy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  // Number of consecutive samples with audio_out equal to level.
  task automatic countRun(input logic level, output int n);
    n = 0;
    while (audio_out === level && n < 5000) begin
      n++;
      tick(1);
    end
  endtask

  initial begin
    int n;
    int n_low;
    int n_high;
    logic seen;

    rst = 1'b1;
    freq = 12'd0;
`ifdef TONE_VOLUME_EN
    vol = 4'd0;
`endif
    tick(3);
    checkOutput("rst_audio", 32'(audio_out), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_half_period", 32'(half_period), 0);
    checkOutput("rst_tone_active", 32'(tone_active), 0);

    // First note from silence.
    rst = 1'b0;
    applyStimulus(12'd440);
    tick(1);
    countBusy(n);
    checkOutput("div440_busy_len", 32'(n), 26);
    tick(1);
    checkOutput("c440_half_period", 32'(half_period), 1136);
    checkOutput("c440_tone_active", 32'(tone_active), 1);
    checkOutput("c440_audio_start", 32'(audio_out), 0);
    countRun(1'b0, n_low);
    countRun(1'b1, n_high);
    checkOutput("p440_low", 32'(n_low), 1136);
    checkOutput("p440_high", 32'(n_high), 1136);
    checkOutput("p440_period", 32'(n_low + n_high), 2272);

    // Change to 1000 Hz part way through a low half-cycle.
    n = 0;
    seen = 1'b0;
    while (audio_out === 1'b0 && n < 5000) begin
      n++;
      if (n == 300) applyStimulus(12'd1000);
      if (half_period !== 26'd1136) seen = 1'b1;
      tick(1);
    end
    checkOutput("sw1000_low_len", 32'(n), 1136);
    checkOutput("sw1000_early_commit", 32'(seen), 0);
    checkOutput("sw1000_half_period", 32'(half_period), 500);
    countRun(1'b1, n_high);
    countRun(1'b0, n_low);
    checkOutput("p1000_high", 32'(n_high), 500);
    checkOutput("p1000_low", 32'(n_low), 500);

    // Silence request while the output is high.
    tick(10);
    applyStimulus(12'd0);
    tick(1);
    checkOutput("z_audio", 32'(audio_out), 0);
    checkOutput("z_tone_active", 32'(tone_active), 0);
    checkOutput("z_half_period", 32'(half_period), 0);
    seen = busy;
    repeat (30) begin
      tick(1);
      seen = seen | busy;
    end
    checkOutput("z_busy_never", 32'(seen), 0);

    // freq changes during a division: 440 commits, then 659 only.
    applyStimulus(12'd440);
    tick(1);
    checkOutput("m_busy_start", 32'(busy), 1);
    tick(5);
    applyStimulus(12'd523);
    tick(5);
    applyStimulus(12'd659);
    countBusy(n);
    checkOutput("m_busy_rest", 32'(n), 16);
    tick(1);
    checkOutput("m_first_commit", 32'(half_period), 1136);
    tick(1);
    checkOutput("m_redivide", 32'(busy), 1);
    countBusy(n);
    checkOutput("m_div659_len", 32'(n), 26);
    n = 0;
    while (half_period === 26'd1136 && n < 3000) begin
      n++;
      tick(1);
    end
    checkOutput("m_wait_toggle", 32'(n), 1109);
    checkOutput("m_second_commit", 32'(half_period), 758);
    checkOutput("m_commit_edge_audio", 32'(audio_out), 1);

    // Reset part way through a division.
    applyStimulus(12'd440);
    tick(1);
    tick(9);
    checkOutput("r_in_div", 32'(busy), 1);
    rst = 1'b1;
    tick(1);
    checkOutput("r_audio", 32'(audio_out), 0);
    checkOutput("r_busy", 32'(busy), 0);
    checkOutput("r_half_period", 32'(half_period), 0);
    checkOutput("r_tone_active", 32'(tone_active), 0);
    rst = 1'b0;
    tick(1);
    countBusy(n);
    checkOutput("r_div_len", 32'(n), 26);
    tick(1);
    checkOutput("r_half_period_after", 32'(half_period), 1136);
    checkOutput("r_tone_active_after", 32'(tone_active), 1);

    // Holding the same note triggers nothing.
    seen = 1'b0;
    repeat (100) begin
      tick(1);
      seen = seen | busy | (half_period !== 26'd1136);
    end
    checkOutput("hold_no_action", 32'(seen), 0);

`ifdef TONE_VOLUME_EN
    rst = 1'b1;
    applyStimulus(12'd0);
    tick(2);
    rst = 1'b0;
    vol = 4'd4;
    applyStimulus(12'd1000);
    tick(1);
    countBusy(n);
    checkOutput("v_div_len", 32'(n), 26);
    tick(1);
    checkOutput("v_half_period", 32'(half_period), 500);
    tick(500);
    n = 0;
    repeat (480) begin
      if (audio_out === 1'b1) n++;
      tick(1);
    end
    checkOutput("v4_ones", 32'(n), 120);
    vol = 4'd0;
    n = 0;
    repeat (1000) begin
      if (audio_out !== 1'b0) n++;
      tick(1);
    end
    checkOutput("v0_ones", 32'(n), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
